jtroadf_rom32_slot: RTL
=======================

# jtroadf_rom32_slot

Single 32-bit read slot between a graphics consumer (scroll or object tile fetcher in jtroadf video) and the shared 16-bit SDRAM request bus. It converts an address plus chip-select into one SDRAM request, assembles two consecutive 16-bit words into a 32-bit result, and holds it in a one-entry cache. Repeated reads of the same address are then answered with no SDRAM traffic. One instance serves each 32-bit graphics slot ahead of the SDRAM arbiter.

## Interface
Parameters:
- AW, 14: width of `addr` in 16-bit-word units. `addr[0]` is ignored, because a 32-bit read is always word-pair aligned.
- OFFSET, 22'd0: SDRAM word offset added to every request address.

Ports:
- clk  in  1  system clock; the block has one clock only.
- rst  in  1  asynchronous, active-high reset.
- cs  in  1  read request from the consumer.
- addr  in  AW  requested 16-bit-word address.
- ok  out  1  `dout` is valid for the current `addr`.
- dout  out  32  assembled data: first word in [15:0], second word in [31:16].
- downloading  in  1  ROM download in progress.
- sdram_req  out  1  request to the SDRAM arbiter.
- sdram_addr  out  22  request word address.
- sdram_ack  in  1  arbiter accepted the request (one-cycle pulse).
- data_dst  in  1  `data_read` carries a word for this slot (one pulse per word).
- data_rdy  in  1  last word of the burst; coincides with the second `data_dst`.
- data_read  in  16  SDRAM read data.

## Operation
- State held:
  - FSM: IDLE, REQ, W0, W1.
  - `tag[AW-2:0]` and `valid`.
  - `dout` register.
  - `fetch_addr` (latched `addr[AW-1:1]`).
- Hit condition: `ok = cs & valid & (addr[AW-1:1]==tag) & ~downloading`.
  - Combinational from registered state, so a hit is answered in zero cycles.
- IDLE:
  - `cs` high and not a hit, with `downloading` low → latch `fetch_addr`, set `sdram_req`, go to REQ.
  - `cs` low → stay in IDLE, no request.
- `sdram_addr = OFFSET + {fetch_addr,1'b0}`, 22-bit modulo arithmetic. It is held stable from REQ entry until the return to IDLE.
- REQ: `sdram_req` stays high until `sdram_ack` is sampled high. Then `sdram_req` clears at that edge and the FSM goes to W0.
- W0: on `data_dst`, capture `data_read` into `dout[15:0]` and go to W1.
- W1: on `data_dst`, capture into `dout[31:16]`, set `tag=fetch_addr` and `valid=1`, then go to IDLE.
  - `data_rdy` is not required to advance.
  - `data_dst` seen in IDLE or REQ is ignored.
- `valid` is cleared at REQ entry, so `ok` never reports a partially written `dout`.
- An address change mid-fetch does not abort the fetch. The fetch completes with the old `fetch_addr`. If the new `addr` mismatches, `ok` stays low and a new fetch starts from IDLE the next cycle.
- `cs` dropping mid-fetch does not abort the fetch; the cache is filled normally.
- `downloading` high is a synchronous flush:
  - `valid=0` and `sdram_req=0`; the FSM forces IDLE at the next edge from any state.
  - No requests are issued while `downloading` is high.
  - Words still arriving are ignored.

## Timing
- Reset values: FSM=IDLE, `sdram_req=0`, `valid=0`, `ok=0`, `dout=0`, `tag=0`, `sdram_addr=OFFSET`.
- Miss latency, counted from the first edge with `cs` high and a miss:
  - edge 0: `sdram_req` rises.
  - edge a (`sdram_ack`): `sdram_req` falls.
  - second `data_dst` edge: `valid` is set, and `ok` is high in the following cycle.
- With ack and two back-to-back `data_dst` cycles arriving immediately, the minimum miss-to-ok time is 4 cycles.
- Hit latency is 0 cycles.
- `sdram_req` never drops before `sdram_ack`. No second request is raised until the FSM returns to IDLE, which gives at least one IDLE cycle between requests.

## Test plan
- Reset, then `cs=1`, `addr=14'h0010`, OFFSET=22'h8000 → `sdram_req=1` and `sdram_addr=22'h8010` one edge later. Ack, then words 16'h1234 and 16'h5678 → `dout=32'h5678_1234`, `ok=1`.
- Repeat the same `addr`, and also `addr=14'h0011` → `ok=1` combinationally with no new `sdram_req`.
- Hold `sdram_ack` low for 20 cycles → `sdram_req` stays high and `sdram_addr` stays stable; `ok=0` throughout.
- Change `addr` to 14'h0020 between ack and the first word → fetch completes with tag 0x08, `ok=0`, then a new request with `sdram_addr=OFFSET+22'h20`.
- Assert `downloading` during W0 → `sdram_req=0`, `valid=0`, FSM=IDLE; later `data_dst` pulses leave `dout` unchanged.
- Assert asynchronous reset mid-REQ → outputs immediately return to their reset values, without waiting for a clock edge.

Source files
------------

// File: rtl/jtroadf_rom32_slot_if.sv
// Bus bundle for one 32-bit graphics ROM slot: the consumer side
// (cs/addr/ok/dout/downloading) and the 16-bit SDRAM request side.
interface jtroadf_rom32_slot_if #(
  parameter int AW = 14
);
  logic          cs;
  logic [AW-1:0] addr;
  logic          ok;
  logic [31:0]   dout;
  logic          downloading;
  logic          sdram_req;
  logic [21:0]   sdram_addr;
  logic          sdram_ack;
  logic          data_dst;
  logic          data_rdy;
  logic [15:0]   data_read;

  // The slot itself.
  modport slave (
    input  cs, addr, downloading, sdram_ack, data_dst, data_rdy, data_read,
    output ok, dout, sdram_req, sdram_addr
  );

  // Whatever drives the slot: consumer plus SDRAM arbiter.
  modport master (
    output cs, addr, downloading, sdram_ack, data_dst, data_rdy, data_read,
    input  ok, dout, sdram_req, sdram_addr
  );
endinterface

// File: rtl/jtroadf_rom32_slot.sv
// 32-bit read slot with a one-entry cache in front of the shared 16-bit
// SDRAM bus. A miss issues one request, assembles two returned words
// (first word low, second word high) and tags the result; a repeated
// read of the same word pair is answered combinationally.
module jtroadf_rom32_slot #(
  parameter int          AW     = 14,
  parameter logic [21:0] OFFSET = 22'd0
) (
  input  logic                  clk,
  input  logic                  rst,
  jtroadf_rom32_slot_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_W0   = 2'd2,
    ST_W1   = 2'd3
  } state_t;

  state_t        state_q;
  logic          valid_q;
  logic [AW-2:0] tag_q;
  logic [AW-2:0] fetch_addr_q;
  logic [31:0]   dout_q;
  logic          req_q;
  logic [21:0]   sdram_addr_q;

  logic [AW-2:0] word_pair_s;
  logic [21:0]   pair_base_s;
  logic [21:0]   sdram_addr_d;
  logic          hit_s;
  logic          unused_s;

  // addr[0] is irrelevant for an aligned pair; the burst end marker is
  // implied by the second data_dst, so data_rdy is not needed either.
  assign unused_s    = &{1'b0, bus.data_rdy, bus.addr[0]};

  assign word_pair_s = bus.addr[AW-1:1];

  // Request address for a new fetch: pair-aligned word address plus offset, mod 2^22.
  always_comb begin
    pair_base_s            = 22'd0;
    pair_base_s[AW-1:0]    = {word_pair_s, 1'b0};
    sdram_addr_d           = OFFSET + pair_base_s;
  end

  // Zero-cycle hit from registered cache state; a download masks it.
  assign hit_s = bus.cs & valid_q & (word_pair_s == tag_q) & ~bus.downloading;

  // Fetch FSM with registered request, address, data and cache tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      valid_q      <= 1'b0;
      tag_q        <= '0;
      fetch_addr_q <= '0;
      dout_q       <= 32'd0;
      req_q        <= 1'b0;
      sdram_addr_q <= OFFSET;
    end else if (bus.downloading) begin
      // ROM contents are changing: drop the cache and any fetch in flight.
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.cs && !hit_s) begin
            fetch_addr_q <= word_pair_s;
            sdram_addr_q <= sdram_addr_d;
            req_q        <= 1'b1;
            // dout is about to be overwritten, so never report it as valid.
            valid_q      <= 1'b0;
            state_q      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.sdram_ack) begin
            req_q   <= 1'b0;
            state_q <= ST_W0;
          end
        end
        ST_W0: begin
          if (bus.data_dst) begin
            dout_q[15:0] <= bus.data_read;
            state_q      <= ST_W1;
          end
        end
        ST_W1: begin
          if (bus.data_dst) begin
            dout_q[31:16] <= bus.data_read;
            tag_q         <= fetch_addr_q;
            valid_q       <= 1'b1;
            state_q       <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ok         = hit_s;
  assign bus.dout       = dout_q;
  assign bus.sdram_req  = req_q;
  assign bus.sdram_addr = sdram_addr_q;

endmodule
